mem_access_ctrl: RTL and testbench

- Parametrised access controller plus storage array for the memory-cell subsystem.
- Generalises the 1-bit cell FSM (sel/op in, rw/valid out) to a DEPTH x DATA_W word array.
- Adds an address/data path, a multi-cycle settle counter, a 4-phase sel/valid handshake, abort on early sel release, and an out-of-range error flag.
- Sits between the test/host logic and the array; one access in flight at a time.

---
 rtl/mem_access_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Access controller and DEPTH x DATA_W storage array with a 4-phase sel/valid
// handshake, a multi-cycle settle counter, early-release abort and range error.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 12,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rw,
    output logic              valid,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int unsigned CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        STABLE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rw_q, rw_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              in_range;

    // Out-of-range addresses are flagged, never wrapped, so every array
    // access below is guarded by in_range.
    assign in_range = (32'(addr_q) < DEPTH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_d   = mem_q;

        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (sel) begin
                    op_d    = op;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_ONE;
                    state_d = op ? WRITE : READ;
                end
            end
            WRITE, READ: begin
                if (!sel) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q < SETTLE_V) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    err_d = !in_range;
                    if (state_q == WRITE) begin
                        if (in_range) begin
                            mem_d[addr_q] = wdata_q;
                        end
                    end else begin
                        rdata_d = in_range ? mem_q[addr_q] : '0;
                    end
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!sel) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are decoded from the next state so they are registered.
        busy_d  = (state_d == WRITE) || (state_d == READ);
        valid_d = (state_d == STABLE);
        rw_d    = (state_d == WRITE) || ((state_d == STABLE) && op_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            rw_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            rw_q    <= rw_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            mem_q   <= mem_d;
        end
    end

    assign rw    = rw_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected results are queued when an
// access is launched and compared when valid rises.
module tb_mem_access_ctrl;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int DEPTH      = 12;
    localparam int SETTLE_CYC = 2;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              rw;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              sel;
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rw;
    logic              valid;
    logic              busy;
    logic [DATA_W-1:0] rdata;
    logic              err;

    exp_t              scoreboard[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] model_rdata;
    int                checks;
    int                failures;
    int                cyc_count;
    int                start_a;
    int                start_b;

    mem_access_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sel(sel),
        .op(op),
        .addr(addr),
        .wdata(wdata),
        .rw(rw),
        .valid(valid),
        .busy(busy),
        .rdata(rdata),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_count = 0;
    always @(posedge clk) cyc_count <= cyc_count + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_rdata = '0;
    endtask

    // Launch one access; abort_after > 0 drops sel after that many busy cycles,
    // mutate changes op/addr/wdata while busy, hold keeps sel one extra cycle.
    task automatic applyStimulus(input logic op_i, input logic [ADDR_W-1:0] addr_i,
                                 input logic [DATA_W-1:0] wdata_i, input int abort_after,
                                 input bit mutate, input bit hold);
        exp_t              e;
        exp_t              got;
        logic [DATA_W-1:0] prev_rdata;
        bit                in_rng;
        int                cyc;

        prev_rdata = model_rdata;
        in_rng     = (int'(addr_i) < DEPTH);
        sel   = 1'b1;
        op    = op_i;
        addr  = addr_i;
        wdata = wdata_i;
        if (abort_after == 0) begin
            e.err = !in_rng;
            e.rw  = op_i;
            if (op_i) begin
                e.rdata = prev_rdata;
                if (in_rng) model_mem[addr_i] = wdata_i;
            end else begin
                e.rdata     = in_rng ? model_mem[addr_i] : '0;
                model_rdata = e.rdata;
            end
            scoreboard.push_back(e);
        end

        @(posedge clk); #1;
        cyc = 0;
        while (!valid && cyc < 20) begin
            checkOutput("busy", 32'(busy), 32'd1);
            checkOutput("rw_busy", 32'(rw), 32'(op_i));
            checkOutput("rdata_hold_busy", 32'(rdata), 32'(prev_rdata));
            if (mutate) begin
                op    = ~op_i;
                addr  = addr_i + 1'b1;
                wdata = 8'h22;
            end
            if (abort_after != 0 && cyc + 1 == abort_after) sel = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (abort_after != 0 && cyc == abort_after) break;
        end

        if (abort_after != 0) begin
            checkOutput("abort_valid", 32'(valid), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_rw", 32'(rw), 32'd0);
            checkOutput("abort_rdata", 32'(rdata), 32'(prev_rdata));
            return;
        end

        checkOutput("latency", 32'(cyc), 32'(SETTLE_CYC));
        if (!valid) begin
            checkOutput("valid_timeout", 32'(valid), 32'd1);
        end
        if (scoreboard.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
            got = e;
        end else begin
            got = scoreboard.pop_front();
        end
        checkOutput("valid", 32'(valid), 32'd1);
        checkOutput("busy_done", 32'(busy), 32'd0);
        checkOutput("rdata", 32'(rdata), 32'(got.rdata));
        checkOutput("err", 32'(err), 32'(got.err));
        checkOutput("rw_done", 32'(rw), 32'(got.rw));

        if (hold) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", 32'(valid), 32'd1);
            checkOutput("hold_rdata", 32'(rdata), 32'(got.rdata));
            checkOutput("hold_err", 32'(err), 32'(got.err));
        end

        sel = 1'b0;
        @(posedge clk); #1;
        checkOutput("release_valid", 32'(valid), 32'd0);
        checkOutput("release_err", 32'(err), 32'd0);
        checkOutput("release_rw", 32'(rw), 32'd0);
        checkOutput("release_rdata", 32'(rdata), 32'(got.rdata));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        op       = 1'b0;
        addr     = '0;
        wdata    = '0;
        rst_n    = 1'b0;
        clearModel();

        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rw", 32'(rw), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] write and read back");
        applyStimulus(1'b1, 4'd3, 8'hA5, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd3, 8'h00, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd4, 8'h00, 0, 1'b0, 1'b0);

        $display("[TB] abort");
        applyStimulus(1'b1, 4'd5, 8'h3C, 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd3, 8'h00, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd5, 8'h00, 0, 1'b0, 1'b0);

        $display("[TB] out of range");
        applyStimulus(1'b1, 4'd13, 8'hFF, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd13, 8'h00, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd1, 8'h00, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd15, 8'h00, 0, 1'b0, 1'b0);

        $display("[TB] input change mid-access");
        applyStimulus(1'b1, 4'd7, 8'h11, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd7, 8'h00, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd8, 8'h00, 0, 1'b0, 1'b0);

        $display("[TB] back-to-back writes");
        start_a = cyc_count;
        applyStimulus(1'b1, 4'd9, 8'h5A, 0, 1'b0, 1'b0);
        start_b = cyc_count;
        applyStimulus(1'b1, 4'd10, 8'h6B, 0, 1'b0, 1'b0);
        checkOutput("b2b_period", 32'(start_b - start_a), 32'(SETTLE_CYC + 2));
        applyStimulus(1'b0, 4'd9, 8'h00, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd10, 8'h00, 0, 1'b0, 1'b0);

        $display("[TB] reset mid-read");
        sel  = 1'b1;
        op   = 1'b0;
        addr = 4'd10;
        @(posedge clk); #1;
        checkOutput("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_valid", 32'(valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_rw", 32'(rw), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        checkOutput("midrst_rdata", 32'(rdata), 32'd0);
        sel   = 1'b0;
        rst_n = 1'b1;
        clearModel();
        @(posedge clk); #1;
        applyStimulus(1'b0, 4'd3, 8'h00, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd9, 8'h00, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
